data_memory_mc: RTL and testbench

- Parametrised successor to the single-cycle word data memory, for the pipelined/multi-cycle core.
- Adds a valid/ready request and response handshake with configurable wait states.
- Adds byte/half/word loads and stores with sign or zero extension, byte-lane write enables, and misalignment error reporting.
- Sits between the MEM stage (or a multi-cycle controller) and a word-organised storage array.

---
 rtl/data_memory_mc_pkg.sv | 48 ++++
 rtl/data_memory_mc_if.sv | 26 ++
 rtl/mem_array_be.sv | 32 +++
 rtl/data_memory_mc.sv | 141 ++++++++++++++
 tb/tb_data_memory_mc.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_mc_pkg.sv
// Shared definitions for the multi-cycle data memory: access sizes,
// controller states and the byte-lane helpers used by the top level.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Reserved size, or a half/word that does not sit on its natural boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    // Lanes touched by a store; little-endian, lane 0 = bits [7:0].
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lane;
            SZ_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // Right-justify the addressed byte/half and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: load_extract = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: load_extract = {{16{~uns & sh[15]}}, sh[15:0]};
            SZ_WORD: load_extract = word;
            default: load_extract = '0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_mc_if.sv
// Request/response handshake bundle between the MEM stage and data_memory_mc.
interface data_memory_mc_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mem_array_be.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
module mem_array_be #(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write; unselected lanes keep their contents.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read; returns the pre-write word on a same-edge collision.
    always_ff @(posedge clock) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle byte/half/word data memory with valid/ready request and
// response channels and a configurable number of wait states.
module data_memory_mc
    import mem_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = $clog2(DEPTH) + 2,
    parameter int WAIT_STATES = 0
) (
    input  logic            clock,
    input  logic            reset,
    data_memory_mc_if.slave bus
);

    localparam logic [3:0] LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state;
    logic [3:0]        wcnt;

    logic              c_write;
    logic [1:0]        c_size;
    logic              c_uns;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic              c_err;

    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_error_q;

    logic              accept;
    logic              commit;
    logic              use_live;
    logic              a_write;
    logic [1:0]        a_size;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic              a_err;
    logic [31:0]       a_wdata_al;
    logic [31:0]       rd_word;

    assign accept = (state == IDLE) && bus.req_valid;

    // With no wait states the commit edge is the acceptance edge, so the
    // array is fed straight from the request; otherwise from the captured copy.
    assign commit   = reset && ((accept && (WAIT_STATES == 0)) ||
                                ((state == WAIT) && (wcnt == LAST)));
    assign use_live = (state == IDLE);

    // Select the source of the committed access and replicate store data across lanes.
    always_comb begin
        a_write = use_live ? bus.req_write : c_write;
        a_size  = use_live ? bus.req_size  : c_size;
        a_addr  = use_live ? bus.req_addr  : c_addr;
        a_wdata = use_live ? bus.req_wdata : c_wdata;
        a_err   = misaligned(a_size, a_addr[1:0]);
        case (a_size)
            SZ_BYTE: a_wdata_al = {4{a_wdata[7:0]}};
            SZ_HALF: a_wdata_al = {2{a_wdata[15:0]}};
            default: a_wdata_al = a_wdata;
        endcase
    end

    mem_array_be #(
        .DEPTH(DEPTH),
        .IDX_W(ADDR_W - 2)
    ) u_array (
        .clock(clock),
        .we   (commit && a_write && !a_err),
        .be   (byte_en(a_size, a_addr[1:0])),
        .waddr(a_addr[ADDR_W-1:2]),
        .wdata(a_wdata_al),
        .re   (commit && !a_write && !a_err),
        .raddr(a_addr[ADDR_W-1:2]),
        .rdata(rd_word)
    );

    // Capture the request at acceptance so the requester is free to move on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c_write <= 1'b0;
            c_size  <= SZ_BYTE;
            c_uns   <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
            c_err   <= 1'b0;
        end else if (accept) begin
            c_write <= bus.req_write;
            c_size  <= bus.req_size;
            c_uns   <= bus.req_unsigned;
            c_addr  <= bus.req_addr;
            c_wdata <= bus.req_wdata;
            c_err   <= misaligned(bus.req_size, bus.req_addr[1:0]);
        end
    end

    // Transaction sequencing: accept, wait out the configured latency, then hold the response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wcnt        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        state <= (WAIT_STATES == 0) ? RESP : WAIT;
                        wcnt  <= '0;
                    end
                end
                WAIT: begin
                    if (wcnt == LAST) state <= RESP;
                    else              wcnt  <= wcnt + 4'd1;
                end
                RESP: begin
                    // First RESP cycle formats the array output; later cycles hold it.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= c_err;
                        rsp_rdata_q <= (c_err || c_write) ? '0
                                     : load_extract(rd_word, c_size, c_addr[1:0], c_uns);
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_memory_mc.sv
// Bench for data_memory_mc: one instance with no wait states, one with three.
module tb_data_memory_mc;
    import mem_pkg::*;

    localparam int AW = 9;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset0, reset3;

    data_memory_mc_if #(.ADDR_W(AW)) bus0 ();
    data_memory_mc_if #(.ADDR_W(AW)) bus3 ();

    data_memory_mc #(.DEPTH(128), .ADDR_W(AW), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset0), .bus(bus0)
    );
    data_memory_mc #(.DEPTH(128), .ADDR_W(AW), .WAIT_STATES(3)) dut3 (
        .clock(clock), .reset(reset3), .bus(bus3)
    );

    // Index 0 drives dut0, index 1 drives dut3.
    logic          rv [2];
    logic          rw [2];
    logic [1:0]    rs [2];
    logic          ru [2];
    logic [AW-1:0] ra [2];
    logic [31:0]   rwd[2];
    logic          rr [2];
    logic          rdy[2];
    logic          vld[2];
    logic          eo [2];
    logic [31:0]   rdo[2];

    assign bus0.req_valid    = rv[0];  assign bus3.req_valid    = rv[1];
    assign bus0.req_write    = rw[0];  assign bus3.req_write    = rw[1];
    assign bus0.req_size     = rs[0];  assign bus3.req_size     = rs[1];
    assign bus0.req_unsigned = ru[0];  assign bus3.req_unsigned = ru[1];
    assign bus0.req_addr     = ra[0];  assign bus3.req_addr     = ra[1];
    assign bus0.req_wdata    = rwd[0]; assign bus3.req_wdata    = rwd[1];
    assign bus0.rsp_ready    = rr[0];  assign bus3.rsp_ready    = rr[1];
    assign rdy[0] = bus0.req_ready;    assign rdy[1] = bus3.req_ready;
    assign vld[0] = bus0.rsp_valid;    assign vld[1] = bus3.rsp_valid;
    assign eo[0]  = bus0.rsp_error;    assign eo[1]  = bus3.rsp_error;
    assign rdo[0] = bus0.rsp_rdata;    assign rdo[1] = bus3.rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [7:0]  mb [512];

    // Issue one request (always starting at a falling edge), push its expected
    // response, then collect the response and compare against the scoreboard head.
    task automatic run(input int d, input string name, input logic w, input logic [1:0] sz,
                       input logic u, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee);
        exp_t e;
        int   lat;
        bit   ok;
        sb.push_back('{rdata: er, err: ee, lat: (d == 0) ? 1 : 4, name: name});
        rw[d] = w; rs[d] = sz; ru[d] = u; ra[d] = a; rwd[d] = wd; rr[d] = 1'b1; rv[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rdy[d]) ok = 1'b1;
            else @(negedge clock);
        end
        if (!ok) begin
            e = sb.pop_front();
            n_checks++; n_fails++;
            $display("FAIL %s: req_ready never rose within 50 cycles", e.name);
            rv[d] = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        rv[d] = 1'b0; ra[d] = ~a; rwd[d] = ~wd; rs[d] = ~sz; rw[d] = ~w; ru[d] = ~u;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (vld[d]) ok = 1'b1;
            else begin
                @(negedge clock);
                lat++;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: rsp_valid never rose within 50 cycles", e.name);
        end else if (rdo[d] !== e.rdata || eo[d] !== e.err || lat != e.lat) begin
            n_fails++;
            $display("FAIL %s: got rdata=%h err=%b latency=%0d, expected rdata=%h err=%b latency=%0d",
                     e.name, rdo[d], eo[d], lat, e.rdata, e.err, e.lat);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset0 = 1'b0; reset3 = 1'b0;
        repeat (3) @(negedge clock);
        reset0 = 1'b1; reset3 = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if ({rdy[d], vld[d], eo[d], rdo[d]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
                n_fails++;
                $display("FAIL reset_state[%0d]: ready=%b valid=%b err=%b rdata=%h, expected ready=1 valid=0 err=0 rdata=00000000",
                         d, rdy[d], vld[d], eo[d], rdo[d]);
            end
        end
    endtask

    task automatic test_word();
        run(0, "sw_08", 1'b1, SZ_WORD, 1'b0, 9'h008, 32'hDEADBEEF, 32'h0, 1'b0);
        run(0, "lw_08", 1'b0, SZ_WORD, 1'b0, 9'h008, 32'h0, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_byte();
        run(0, "sb_09",  1'b1, SZ_BYTE, 1'b0, 9'h009, 32'h12345680, 32'h0, 1'b0);
        run(0, "lw_08b", 1'b0, SZ_WORD, 1'b1, 9'h008, 32'h0, 32'hDEAD80EF, 1'b0);
        run(0, "lb_09",  1'b0, SZ_BYTE, 1'b0, 9'h009, 32'h0, 32'hFFFFFF80, 1'b0);
        run(0, "lbu_09", 1'b0, SZ_BYTE, 1'b1, 9'h009, 32'h0, 32'h00000080, 1'b0);
        run(0, "lh_0a",  1'b0, SZ_HALF, 1'b0, 9'h00A, 32'h0, 32'hFFFFDEAD, 1'b0);
        run(0, "lhu_0a", 1'b0, SZ_HALF, 1'b1, 9'h00A, 32'h0, 32'h0000DEAD, 1'b0);
    endtask

    task automatic test_half_and_errors();
        run(0, "sw_0c",      1'b1, SZ_WORD, 1'b0, 9'h00C, 32'h5555AAAA, 32'h0, 1'b0);
        run(0, "sh_0e",      1'b1, SZ_HALF, 1'b0, 9'h00E, 32'hFFFF1234, 32'h0, 1'b0);
        run(0, "lh_0e",      1'b0, SZ_HALF, 1'b0, 9'h00E, 32'h0, 32'h00001234, 1'b0);
        run(0, "lh_0d_err",  1'b0, SZ_HALF, 1'b0, 9'h00D, 32'h0, 32'h0, 1'b1);
        run(0, "sw_0e_err",  1'b1, SZ_WORD, 1'b0, 9'h00E, 32'hFFFFFFFF, 32'h0, 1'b1);
        run(0, "lw_0d_err",  1'b0, SZ_WORD, 1'b0, 9'h00D, 32'h0, 32'h0, 1'b1);
        run(0, "sz11_st",    1'b1, 2'b11,   1'b0, 9'h00C, 32'h0BADF00D, 32'h0, 1'b1);
        run(0, "sz11_ld",    1'b0, 2'b11,   1'b0, 9'h00C, 32'h0, 32'h0, 1'b1);
        run(0, "lw_0c_kept", 1'b0, SZ_WORD, 1'b0, 9'h00C, 32'h0, 32'h1234AAAA, 1'b0);
    endtask

    task automatic test_wait_states();
        exp_t        e;
        logic [31:0] held;
        run(1, "ws3_sw_10", 1'b1, SZ_WORD, 1'b0, 9'h010, 32'hCAFEF00D, 32'h0, 1'b0);
        run(1, "ws3_lb_11", 1'b0, SZ_BYTE, 1'b0, 9'h011, 32'h0, 32'hFFFFFFF0, 1'b0);
        sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, lat: 4, name: "ws3_lw_hold"});
        rw[1] = 1'b0; rs[1] = SZ_WORD; ru[1] = 1'b0; ra[1] = 9'h010; rr[1] = 1'b0; rv[1] = 1'b1;
        n_checks++;
        if (rdy[1] !== 1'b1) begin
            n_fails++;
            $display("FAIL ws3_ready_idle: ready=%b, expected 1", rdy[1]);
        end
        @(posedge clock);
        @(negedge clock);
        rv[1] = 1'b0; ra[1] = 9'h1FF;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rdy[1] !== 1'b0 || vld[1] !== 1'b0) begin
                n_fails++;
                $display("FAIL ws3_busy_%0d: ready=%b valid=%b, expected ready=0 valid=0", i, rdy[1], vld[1]);
            end
            @(negedge clock);
        end
        e = sb.pop_front();
        n_checks++;
        if (vld[1] !== 1'b1 || rdo[1] !== e.rdata || eo[1] !== e.err) begin
            n_fails++;
            $display("FAIL %s: valid=%b rdata=%h err=%b, expected valid=1 rdata=%h err=%b",
                     e.name, vld[1], rdo[1], eo[1], e.rdata, e.err);
        end
        held = e.rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (vld[1] !== 1'b1 || rdo[1] !== held || rdy[1] !== 1'b0) begin
                n_fails++;
                $display("FAIL ws3_stall_%0d: valid=%b rdata=%h ready=%b, expected valid=1 rdata=%h ready=0",
                         i, vld[1], rdo[1], rdy[1], held);
            end
        end
        rr[1] = 1'b1;
        @(negedge clock);
        n_checks++;
        if (vld[1] !== 1'b0 || rdy[1] !== 1'b1) begin
            n_fails++;
            $display("FAIL ws3_release: valid=%b ready=%b, expected valid=0 ready=1", vld[1], rdy[1]);
        end
    endtask

    task automatic test_reset_in_wait();
        run(1, "ws3_sw_20", 1'b1, SZ_WORD, 1'b0, 9'h020, 32'h11111111, 32'h0, 1'b0);
        rw[1] = 1'b1; rs[1] = SZ_WORD; ra[1] = 9'h020; rwd[1] = 32'hAAAAAAAA; rr[1] = 1'b1; rv[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rv[1] = 1'b0;
        @(negedge clock);
        reset3 = 1'b0;
        repeat (2) @(negedge clock);
        reset3 = 1'b1;
        @(negedge clock);
        n_checks++;
        if (vld[1] !== 1'b0 || rdy[1] !== 1'b1 || eo[1] !== 1'b0 || rdo[1] !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_in_wait: valid=%b ready=%b err=%b rdata=%h, expected 0 1 0 00000000",
                     vld[1], rdy[1], eo[1], rdo[1]);
        end
        run(1, "ws3_lw_20_kept", 1'b0, SZ_WORD, 1'b0, 9'h020, 32'h0, 32'h11111111, 1'b0);
    endtask

    // Back-to-back random traffic against a byte-addressed reference model.
    task automatic test_back_to_back();
        logic          w, u, ee;
        logic [1:0]    sz;
        logic [AW-1:0] a;
        logic [31:0]   wd, er;
        int            nb;
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            a  = AW'(32'h40 + 4 * i);
            for (int b = 0; b < 4; b++) mb[int'(a) + b] = wd[8*b +: 8];
            run(0, "b2b_init", 1'b1, SZ_WORD, 1'b0, a, wd, 32'h0, 1'b0);
        end
        for (int k = 0; k < 60; k++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = AW'(32'h40 + $urandom_range(0, 31));
            wd = $urandom;
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            ee = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
            er = '0;
            if (!ee && w) begin
                for (int b = 0; b < nb; b++) mb[int'(a) + b] = wd[8*b +: 8];
            end else if (!ee) begin
                for (int b = 0; b < nb; b++) er[8*b +: 8] = mb[int'(a) + b];
                if (!u && nb < 4 && er[8*nb-1]) begin
                    for (int b = 8 * nb; b < 32; b++) er[b] = 1'b1;
                end
            end
            run(0, "b2b_rand", w, sz, u, a, wd, er, ee);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; rs[d] = SZ_WORD; ru[d] = 1'b0;
            ra[d] = '0; rwd[d] = '0; rr[d] = 1'b1;
        end
        @(negedge clock);
        test_reset();
        test_word();
        test_byte();
        test_half_and_errors();
        test_wait_states();
        test_reset_in_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
